snax_dream_elementwise_shell: RTL and testbench
===============================================

# snax_dream_elementwise_shell

Parametrised accelerator shell for the DREAM accelerator slot in a SNAX cluster. It joins `NumInputs` streamer read channels beat by beat and applies a CSR-selected lane-wise operation on packed `ElemWidth` elements. It returns results on one streamer write channel. A CSR-launched run processes a programmed number of beats, and busy status plus a cycle counter are exposed through read-only CSRs.

## Interface
- `NumInputs`, 2: number of streamer-to-accelerator channels; legal 2..4.
- `NumPE`, 1: PE replication factor; the beat width is `NumPE*DataWidth`.
- `DataWidth`, 512: data bits per PE.
- `ElemWidth`, 16: lane element width; must divide `NumPE*DataWidth`; legal 8/16/32.
- `RegRWCount`, 3: number of RW CSRs.
- `RegROCount`, 2: number of RO CSRs.
- `RegDataWidth`, 32: CSR width.
- `RegAddrWidth`, 32: CSR address width; not used internally.

Ports:
- `clk_i`  in  1  single clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `stream2acc_data_i`  in  `[NumInputs-1:0][NumPE*DataWidth-1:0]`  input beats.
- `stream2acc_valid_i`  in  `NumInputs`  per-channel valid.
- `stream2acc_ready_o`  out  `NumInputs`  per-channel ready.
- `acc2stream_0_data_o`  out  `NumPE*DataWidth`  result beat.
- `acc2stream_0_valid_o`  out  1  result valid.
- `acc2stream_0_ready_i`  in  1  result ready.
- `csr_reg_set_i`  in  `[RegRWCount-1:0][RegDataWidth-1:0]`  config: reg0 = beat count; reg1[1:0] = op, reg1[8] = signed; reg2[4:0] = mul shift.
- `csr_reg_set_valid_i`  in  1  config valid.
- `csr_reg_set_ready_o`  out  1  config ready.
- `csr_reg_ro_set_o`  out  `[RegROCount-1:0][RegDataWidth-1:0]`  status: ro0[0] = busy; ro1 = cycle counter.

## Operation
- FSM with two states, `IDLE` and `BUSY`. `csr_reg_set_ready_o` is 1 only in `IDLE`.
- Config handshake (`valid & ready`) latches reg0..reg2.
  - If the beat count is nonzero, the FSM goes to `BUSY`; `in_cnt` and `out_cnt` load the count and the cycle counter clears to 0.
  - If the beat count is 0, the FSM stays in `IDLE` and the cycle counter is cleared to 0.
- Input join: a beat is consumed when all `stream2acc_valid_i` are 1, `BUSY`, `in_cnt != 0`, and the output register is empty or draining this cycle.
  - All `stream2acc_ready_o` bits are driven equal to this condition ANDed with their own valid.
  - No channel is consumed alone.
- Ops per lane, with operands `x0..x(N-1)`:
  - 0 = sum of all inputs, modulo 2^ElemWidth.
  - 1 = `x0` minus the sum of the rest, modulo 2^ElemWidth.
  - 2 = `(x0*x1)` at full 2*ElemWidth width, arithmetic right shift (signed) or logical right shift (unsigned) by the shift amount, low ElemWidth bits kept; inputs 2 and up are ignored.
  - 3 = maximum of all inputs, signed or unsigned per reg1[8].
- Output register: a single stage with valid/ready. It holds data stable while `acc2stream_0_valid_o & !acc2stream_0_ready_i`.
- `out_cnt` decrements on each accepted output beat. When `out_cnt` reaches 0 the FSM returns to `IDLE`.
- ro0[0] is 1 exactly in `BUSY`.
- ro1 increments by 1 every cycle in `BUSY`, saturates at 2^32-1, and holds after the run until the next launch.
- Extra input beats after `in_cnt` reaches 0 are not accepted; their ready stays 0.

## Timing
- Reset values: FSM = `IDLE`, `acc2stream_0_valid_o` = 0, `acc2stream_0_data_o` = 0, `stream2acc_ready_o` = 0, `csr_reg_set_ready_o` = 1, all RO CSRs = 0, all counters = 0.
- Assertion of `rst_ni` mid-run aborts immediately with the same values; any in-flight beat is dropped.
- Latency: result is valid the cycle after the input join.
- Throughput: 1 beat/cycle when downstream ready is held high.
- `BUSY` is entered the cycle after the config handshake; inputs can be accepted from that cycle on.
- `IDLE` is entered the cycle after the last output handshake. `csr_reg_set_ready_o` rises in that same cycle, so a back-to-back launch is possible.
- Simultaneous events: load and drain of the output register in the same cycle is allowed; valid stays 1 and data updates.
- Config writes arriving during `BUSY` stall (ready = 0) and are never dropped.

## Test plan
- `NumInputs`=2, 16-bit unsigned add, count 4: lanes 0x0001 + 0xFFFF give 0x0000; exactly 4 output beats; busy deasserts; ro1 = 5 with no stalls.
- Signed max, `NumInputs`=3, lane values -3, 7, -100 -> 7. Unsigned max with 0xFFFD, 0x0007, 0xFF9C -> 0xFFFD.
- Signed mul with shift 4: 0x0100 * 0xFFF0 (256 * -16) gives -4096 >> 4 = 0xFF00.
- Backpressure: hold `acc2stream_0_ready_i`=0 for 3 cycles mid-run -> data is stable, `stream2acc_ready_o`=0 once the register is full, no beat is lost or duplicated, and the beat count is still correct.
- Valid skew: channel 1 valid arrives 2 cycles after channel 0 -> no channel is consumed until both are valid, and the channels are consumed in the same cycle.
- Edge cases:
  - Count 0 launch -> busy never rises and ro1 = 0.
  - Config write during `BUSY` -> ready = 0 until `IDLE`, then it is accepted.
  - Reset asserted mid-run -> all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/snax_dream_elementwise_shell_if.sv
// Streamer and CSR bundle for the DREAM elementwise shell.
// The shell takes the slave side; the cluster or a bench drives the master side.
interface snax_dream_elementwise_shell_if #(
    parameter int unsigned NumInputs    = 2,
    parameter int unsigned NumPE        = 1,
    parameter int unsigned DataWidth    = 512,
    parameter int unsigned RegRWCount   = 3,
    parameter int unsigned RegROCount   = 2,
    parameter int unsigned RegDataWidth = 32
);
    localparam int unsigned BeatW = NumPE * DataWidth;

    logic [NumInputs-1:0][BeatW-1:0]         stream2acc_data_i;
    logic [NumInputs-1:0]                    stream2acc_valid_i;
    logic [NumInputs-1:0]                    stream2acc_ready_o;
    logic [BeatW-1:0]                        acc2stream_0_data_o;
    logic                                    acc2stream_0_valid_o;
    logic                                    acc2stream_0_ready_i;
    logic [RegRWCount-1:0][RegDataWidth-1:0] csr_reg_set_i;
    logic                                    csr_reg_set_valid_i;
    logic                                    csr_reg_set_ready_o;
    logic [RegROCount-1:0][RegDataWidth-1:0] csr_reg_ro_set_o;

    modport slave (
        input  stream2acc_data_i,
        input  stream2acc_valid_i,
        output stream2acc_ready_o,
        output acc2stream_0_data_o,
        output acc2stream_0_valid_o,
        input  acc2stream_0_ready_i,
        input  csr_reg_set_i,
        input  csr_reg_set_valid_i,
        output csr_reg_set_ready_o,
        output csr_reg_ro_set_o
    );

    modport master (
        output stream2acc_data_i,
        output stream2acc_valid_i,
        input  stream2acc_ready_o,
        input  acc2stream_0_data_o,
        input  acc2stream_0_valid_o,
        output acc2stream_0_ready_i,
        output csr_reg_set_i,
        output csr_reg_set_valid_i,
        input  csr_reg_set_ready_o,
        input  csr_reg_ro_set_o
    );
endinterface

// File: rtl/snax_dream_elementwise_shell.sv
// DREAM elementwise shell: joins N streamer inputs, applies a lane-wise op,
// and returns one result beat per joined beat through a one-entry output register.
module snax_dream_elementwise_shell #(
    parameter int unsigned NumInputs    = 2,
    parameter int unsigned NumPE        = 1,
    parameter int unsigned DataWidth    = 512,
    parameter int unsigned ElemWidth    = 16,
    parameter int unsigned RegRWCount   = 3,
    parameter int unsigned RegROCount   = 2,
    parameter int unsigned RegDataWidth = 32,
    parameter int unsigned RegAddrWidth = 32
) (
    input logic                     clk_i,
    input logic                     rst_ni,
    snax_dream_elementwise_shell_if.slave bus
);
    localparam int unsigned BW = NumPE * DataWidth;
    localparam int unsigned EW = ElemWidth;
    localparam int unsigned NL = BW / EW;
    localparam int unsigned CW = RegDataWidth;

    if (NumInputs < 2 || NumInputs > 4) begin : g_bad_inputs
        $error("NumInputs must be 2..4");
    end
    if (!(EW == 8 || EW == 16 || EW == 32) || (BW % EW) != 0) begin : g_bad_elem
        $error("ElemWidth must be 8/16/32 and divide the beat width");
    end
    if (RegROCount < 2 || RegRWCount < 3 || CW < 10) begin : g_bad_csr
        $error("CSR file too small for this shell");
    end
    if (RegAddrWidth == 0) begin : g_bad_addr
        $error("RegAddrWidth must be nonzero");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e          r_state;
    state_e          w_next;
    logic [CW-1:0]   r_in_cnt;
    logic [CW-1:0]   r_out_cnt;
    logic [CW-1:0]   r_cycle;
    logic [1:0]      r_op;
    logic            r_signed;
    logic [4:0]      r_shift;
    logic            r_out_valid;
    logic [BW-1:0]   r_out_data;
    logic [BW-1:0]   w_res;
    logic            w_cfg_fire;
    logic            w_all_valid;
    logic            w_drain;
    logic            w_join;
    logic            w_last;
    logic            w_unused_cfg;

    assign w_unused_cfg = ^{bus.csr_reg_set_i[1][CW-1:9],
                            bus.csr_reg_set_i[1][7:2],
                            bus.csr_reg_set_i[2][CW-1:5]};

    assign w_cfg_fire  = bus.csr_reg_set_valid_i & (r_state == IDLE);
    assign w_all_valid = &bus.stream2acc_valid_i;
    assign w_drain     = r_out_valid & bus.acc2stream_0_ready_i;
    assign w_join      = w_all_valid & (r_state == BUSY)
                       & (r_in_cnt != '0)
                       & (~r_out_valid | bus.acc2stream_0_ready_i);
    assign w_last      = w_drain & (r_out_cnt == CW'(1));

    // Lane datapath: one combinational slice per packed element.
    for (genvar l = 0; l < NL; l++) begin : g_lane
        logic [EW-1:0]          w_x [NumInputs];
        logic [EW-1:0]          w_sum;
        logic [EW-1:0]          w_rest;
        logic [EW-1:0]          w_max;
        logic [EW-1:0]          w_y;
        logic signed [2*EW-1:0] w_sa;
        logic signed [2*EW-1:0] w_sb;
        logic signed [2*EW-1:0] w_sprod;
        logic signed [2*EW-1:0] w_sshr;
        logic [2*EW-1:0]        w_ua;
        logic [2*EW-1:0]        w_ub;
        logic [2*EW-1:0]        w_uprod;
        logic [2*EW-1:0]        w_ushr;
        logic [2*EW-1:0]        w_mul;
        logic                   w_unused_hi;

        for (genvar c = 0; c < NumInputs; c++) begin : g_ch
            assign w_x[c] = bus.stream2acc_data_i[c][l*EW +: EW];
        end

        // Products are formed at double width so the shift sees every bit.
        assign w_sa    = {{EW{w_x[0][EW-1]}}, w_x[0]};
        assign w_sb    = {{EW{w_x[1][EW-1]}}, w_x[1]};
        assign w_ua    = {{EW{1'b0}}, w_x[0]};
        assign w_ub    = {{EW{1'b0}}, w_x[1]};
        assign w_sprod = w_sa * w_sb;
        assign w_uprod = w_ua * w_ub;
        assign w_sshr  = w_sprod >>> r_shift;
        assign w_ushr  = w_uprod >> r_shift;
        assign w_mul   = r_signed ? w_sshr : w_ushr;
        assign w_unused_hi = ^w_mul[2*EW-1:EW];

        // Reductions over every channel: total, tail sum and running max.
        always_comb begin
            w_sum  = w_x[0];
            w_rest = '0;
            w_max  = w_x[0];
            for (int k = 1; k < int'(NumInputs); k++) begin
                w_sum  = w_sum + w_x[k];
                w_rest = w_rest + w_x[k];
                if (r_signed ? ($signed(w_x[k]) > $signed(w_max))
                             : (w_x[k] > w_max)) begin
                    w_max = w_x[k];
                end
            end
        end

        // Op select for this lane.
        always_comb begin
            w_y = w_sum;
            unique case (r_op)
                2'd0: w_y = w_sum;
                2'd1: w_y = w_x[0] - w_rest;
                2'd2: w_y = w_mul[EW-1:0];
                2'd3: w_y = w_max;
            endcase
        end

        assign w_res[l*EW +: EW] = w_y;
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: launch on a nonzero count, finish on the last drained beat.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_cfg_fire && (bus.csr_reg_set_i[0] != '0)) begin
                    w_next = BUSY;
                end
            end
            BUSY: begin
                if (w_last) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State-derived handshakes and status CSRs.
    always_comb begin
        bus.csr_reg_set_ready_o = (r_state == IDLE);
        bus.stream2acc_ready_o  = {NumInputs{w_join}} & bus.stream2acc_valid_i;
        bus.csr_reg_ro_set_o    = '0;
        bus.csr_reg_ro_set_o[0][0] = (r_state == BUSY);
        bus.csr_reg_ro_set_o[1]    = r_cycle;
    end

    // Run configuration is captured only at the launch handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_op     <= '0;
            r_signed <= 1'b0;
            r_shift  <= '0;
        end else if (w_cfg_fire) begin
            r_op     <= bus.csr_reg_set_i[1][1:0];
            r_signed <= bus.csr_reg_set_i[1][8];
            r_shift  <= bus.csr_reg_set_i[2][4:0];
        end
    end

    // Beat counters: inputs count joins, outputs count drained beats.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
        end else begin
            if (w_cfg_fire) begin
                r_in_cnt <= bus.csr_reg_set_i[0];
            end else if (w_join) begin
                r_in_cnt <= r_in_cnt - CW'(1);
            end
            if (w_cfg_fire) begin
                r_out_cnt <= bus.csr_reg_set_i[0];
            end else if (w_drain) begin
                r_out_cnt <= r_out_cnt - CW'(1);
            end
        end
    end

    // Saturating run-time counter, cleared on every launch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cycle <= '0;
        end else if (w_cfg_fire) begin
            r_cycle <= '0;
        end else if ((r_state == BUSY) && (r_cycle != '1)) begin
            r_cycle <= r_cycle + CW'(1);
        end
    end

    // One-entry output register; a join may refill it while it drains.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_join) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_res;
        end else if (w_drain) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.acc2stream_0_valid_o = r_out_valid;
    assign bus.acc2stream_0_data_o  = r_out_data;
endmodule

// File: tb/tb_snax_dream_elementwise_shell.sv
// Directed bench for the DREAM elementwise shell, three inputs, 16-bit lanes.
// Expected beats are hand-computed constants.
module tb_snax_dream_elementwise_shell;
    typedef logic [511:0] beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    snax_dream_elementwise_shell_if #(.NumInputs(3)) bus();

    snax_dream_elementwise_shell #(.NumInputs(3)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    function automatic beat_t rep(input logic [15:0] v);
        return {32{v}};
    endfunction

    function automatic beat_t rep2(input logic [15:0] hi, input logic [15:0] lo);
        return {16{hi, lo}};
    endfunction

    task automatic set_in(input beat_t d0, input beat_t d1, input beat_t d2,
                          input logic [2:0] v);
        bus.stream2acc_data_i[0] = d0;
        bus.stream2acc_data_i[1] = d1;
        bus.stream2acc_data_i[2] = d2;
        bus.stream2acc_valid_i   = v;
    endtask

    task automatic launch(input logic [31:0] cnt, input logic [1:0] op,
                          input logic sg, input logic [4:0] sh);
        int k;
        @(negedge clk);
        bus.csr_reg_set_i[0] = cnt;
        bus.csr_reg_set_i[1] = {23'b0, sg, 6'b0, op};
        bus.csr_reg_set_i[2] = {27'b0, sh};
        bus.csr_reg_set_valid_i = 1'b1;
        k = 0;
        while (bus.csr_reg_set_ready_o !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 100) begin
            errors++;
            $display("FAIL launch_timeout ready=%b required=1", bus.csr_reg_set_ready_o);
        end
        @(negedge clk);
        bus.csr_reg_set_valid_i = 1'b0;
    endtask

    task automatic run(input logic [31:0] cnt, input logic [1:0] op,
                       input logic sg, input logic [4:0] sh,
                       input beat_t d0, input beat_t d1, input beat_t d2,
                       output int n, output beat_t first, output beat_t last);
        launch(cnt, op, sg, sh);
        bus.acc2stream_0_ready_i = 1'b1;
        set_in(d0, d1, d2, 3'b111);
        n = 0;
        first = '0;
        last = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.acc2stream_0_valid_o) begin
                if (n == 0) first = bus.acc2stream_0_data_o;
                last = bus.acc2stream_0_data_o;
                n++;
            end
            if (!bus.csr_reg_ro_set_o[0][0] && !bus.acc2stream_0_valid_o) break;
        end
        set_in('0, '0, '0, 3'b000);
    endtask

    task automatic test_reset;
        set_in(rep(16'h1111), rep(16'h2222), rep(16'h3333), 3'b111);
        bus.acc2stream_0_ready_i = 1'b1;
        bus.csr_reg_set_valid_i = 1'b0;
        bus.csr_reg_set_i = '0;
        #12;
        checks++;
        if (bus.acc2stream_0_valid_o !== 1'b0) begin
            errors++; $display("FAIL rst_valid got=%b exp=0", bus.acc2stream_0_valid_o);
        end
        checks++;
        if (bus.acc2stream_0_data_o !== '0) begin
            errors++; $display("FAIL rst_data got=%h exp=0", bus.acc2stream_0_data_o);
        end
        checks++;
        if (bus.stream2acc_ready_o !== 3'b000) begin
            errors++; $display("FAIL rst_in_ready got=%b exp=000", bus.stream2acc_ready_o);
        end
        checks++;
        if (bus.csr_reg_set_ready_o !== 1'b1) begin
            errors++; $display("FAIL rst_csr_ready got=%b exp=1", bus.csr_reg_set_ready_o);
        end
        checks++;
        if (bus.csr_reg_ro_set_o[0] !== 32'd0 || bus.csr_reg_ro_set_o[1] !== 32'd0) begin
            errors++;
            $display("FAIL rst_ro got=%h/%h exp=0/0",
                     bus.csr_reg_ro_set_o[0], bus.csr_reg_ro_set_o[1]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_in('0, '0, '0, 3'b000);
    endtask

    task automatic test_add;
        int n;
        beat_t f, l;
        run(4, 2'd0, 1'b0, 5'd0, rep(16'h0001), rep(16'hFFFF), rep(16'h0000), n, f, l);
        checks++;
        if (n != 4) begin errors++; $display("FAIL add_beats got=%0d exp=4", n); end
        checks++;
        if (f !== '0 || l !== '0) begin
            errors++; $display("FAIL add_wrap got=%h exp=0", l);
        end
        checks++;
        if (bus.csr_reg_ro_set_o[0][0] !== 1'b0) begin
            errors++; $display("FAIL add_busy got=1 exp=0");
        end
        checks++;
        if (bus.csr_reg_ro_set_o[1] !== 32'd5) begin
            errors++; $display("FAIL add_cycles got=%0d exp=5", bus.csr_reg_ro_set_o[1]);
        end
        run(1, 2'd0, 1'b0, 5'd0, rep(16'h1234), rep(16'h0101), rep(16'h0002), n, f, l);
        checks++;
        if (n != 1 || l !== rep(16'h1337)) begin
            errors++; $display("FAIL add3 n=%0d got=%h exp=%h", n, l, rep(16'h1337));
        end
        checks++;
        if (bus.csr_reg_ro_set_o[1] !== 32'd2) begin
            errors++; $display("FAIL add3_cycles got=%0d exp=2", bus.csr_reg_ro_set_o[1]);
        end
    endtask

    task automatic test_sub;
        int n;
        beat_t f, l;
        run(1, 2'd1, 1'b0, 5'd0, rep2(16'h0001, 16'h0010), rep2(16'h0002, 16'h0003),
            rep2(16'h0000, 16'h0001), n, f, l);
        checks++;
        if (n != 1 || l !== rep2(16'hFFFF, 16'h000C)) begin
            errors++;
            $display("FAIL sub n=%0d got=%h exp=%h", n, l, rep2(16'hFFFF, 16'h000C));
        end
    endtask

    task automatic test_max;
        int n;
        beat_t f, l;
        run(1, 2'd3, 1'b1, 5'd0, rep2(16'h0005, 16'hFFFD), rep2(16'h0002, 16'h0007),
            rep2(16'h0009, 16'hFF9C), n, f, l);
        checks++;
        if (n != 1 || l !== rep2(16'h0009, 16'h0007)) begin
            errors++;
            $display("FAIL smax n=%0d got=%h exp=%h", n, l, rep2(16'h0009, 16'h0007));
        end
        run(1, 2'd3, 1'b0, 5'd0, rep2(16'h0005, 16'hFFFD), rep2(16'h0002, 16'h0007),
            rep2(16'h0009, 16'hFF9C), n, f, l);
        checks++;
        if (n != 1 || l !== rep2(16'h0009, 16'hFFFD)) begin
            errors++;
            $display("FAIL umax n=%0d got=%h exp=%h", n, l, rep2(16'h0009, 16'hFFFD));
        end
    endtask

    task automatic test_mul;
        int n;
        beat_t f, l;
        run(1, 2'd2, 1'b1, 5'd4, rep2(16'h0100, 16'h0100), rep2(16'h0100, 16'hFFF0),
            rep(16'h7777), n, f, l);
        checks++;
        if (n != 1 || l !== rep2(16'h1000, 16'hFF00)) begin
            errors++;
            $display("FAIL smul n=%0d got=%h exp=%h", n, l, rep2(16'h1000, 16'hFF00));
        end
        run(1, 2'd2, 1'b0, 5'd16, rep2(16'h0100, 16'h0100), rep2(16'h0100, 16'hFFF0),
            rep(16'h7777), n, f, l);
        checks++;
        if (n != 1 || l !== rep2(16'h0001, 16'h00FF)) begin
            errors++;
            $display("FAIL umul n=%0d got=%h exp=%h", n, l, rep2(16'h0001, 16'h00FF));
        end
    endtask

    task automatic test_backpressure;
        beat_t got [4];
        beat_t prev;
        int    bi, no;
        logic  prev_stall, stall_ok, rdy_ok, extra_ok, saw_stall;
        launch(4, 2'd0, 1'b0, 5'd0);
        bi = 0; no = 0; prev = '0;
        prev_stall = 0; stall_ok = 1; rdy_ok = 1; extra_ok = 1; saw_stall = 0;
        for (int i = 0; i < 4; i++) got[i] = '0;
        for (int k = 0; k < 40; k++) begin
            bus.acc2stream_0_ready_i = !(k >= 2 && k < 5);
            if (bi < 4) set_in(rep(16'(bi + 1)), rep(16'h0010), '0, 3'b111);
            else set_in(rep(16'h00AA), rep(16'h0010), '0, 3'b111);
            #1;
            if (prev_stall && bus.acc2stream_0_data_o !== prev) stall_ok = 0;
            if (!bus.acc2stream_0_ready_i && bus.acc2stream_0_valid_o) begin
                saw_stall = 1;
                if (bus.stream2acc_ready_o !== 3'b000) rdy_ok = 0;
            end
            if (bi >= 4 && bus.stream2acc_ready_o !== 3'b000) extra_ok = 0;
            if (bus.acc2stream_0_valid_o && bus.acc2stream_0_ready_i) begin
                if (no < 4) got[no] = bus.acc2stream_0_data_o;
                no++;
            end
            prev_stall = bus.acc2stream_0_valid_o && !bus.acc2stream_0_ready_i;
            prev = bus.acc2stream_0_data_o;
            if (bus.stream2acc_ready_o == 3'b111) bi++;
            if (!bus.csr_reg_ro_set_o[0][0] && !bus.acc2stream_0_valid_o) break;
            @(negedge clk);
        end
        set_in('0, '0, '0, 3'b000);
        bus.acc2stream_0_ready_i = 1'b1;
        checks++;
        if (no != 4 || bi != 4) begin
            errors++; $display("FAIL bp_count out=%0d in=%0d exp=4/4", no, bi);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== rep(16'(16'h0011 + i))) begin
                errors++;
                $display("FAIL bp_beat%0d got=%h exp=%h", i, got[i], rep(16'(16'h0011 + i)));
            end
        end
        checks++;
        if (!stall_ok) begin errors++; $display("FAIL bp_stable got=changed exp=held"); end
        checks++;
        if (!saw_stall || !rdy_ok) begin
            errors++; $display("FAIL bp_in_ready saw=%b ok=%b exp=1/1", saw_stall, rdy_ok);
        end
        checks++;
        if (!extra_ok) begin errors++; $display("FAIL bp_extra got=accepted exp=blocked"); end
    endtask

    task automatic test_skew;
        launch(1, 2'd0, 1'b0, 5'd0);
        bus.acc2stream_0_ready_i = 1'b1;
        set_in(rep(16'h0101), rep(16'h0202), rep(16'h0303), 3'b101);
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (bus.stream2acc_ready_o !== 3'b000 || bus.acc2stream_0_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL skew_wait%0d ready=%b valid=%b exp=000/0", k,
                         bus.stream2acc_ready_o, bus.acc2stream_0_valid_o);
            end
            @(negedge clk);
        end
        bus.stream2acc_valid_i = 3'b111;
        #1;
        checks++;
        if (bus.stream2acc_ready_o !== 3'b111) begin
            errors++; $display("FAIL skew_join got=%b exp=111", bus.stream2acc_ready_o);
        end
        @(negedge clk);
        set_in('0, '0, '0, 3'b000);
        checks++;
        if (bus.acc2stream_0_valid_o !== 1'b1 || bus.acc2stream_0_data_o !== rep(16'h0606)) begin
            errors++;
            $display("FAIL skew_data valid=%b got=%h exp=%h", bus.acc2stream_0_valid_o,
                     bus.acc2stream_0_data_o, rep(16'h0606));
        end
        @(negedge clk);
        checks++;
        if (bus.csr_reg_ro_set_o[0][0] !== 1'b0) begin
            errors++; $display("FAIL skew_done busy=1 exp=0");
        end
    endtask

    task automatic test_zero;
        logic saw_busy;
        saw_busy = 0;
        launch(0, 2'd0, 1'b0, 5'd0);
        for (int k = 0; k < 4; k++) begin
            if (bus.csr_reg_ro_set_o[0][0]) saw_busy = 1;
            @(negedge clk);
        end
        checks++;
        if (saw_busy) begin errors++; $display("FAIL zero_busy got=1 exp=0"); end
        checks++;
        if (bus.csr_reg_ro_set_o[1] !== 32'd0) begin
            errors++; $display("FAIL zero_cycles got=%0d exp=0", bus.csr_reg_ro_set_o[1]);
        end
        checks++;
        if (bus.csr_reg_set_ready_o !== 1'b1) begin
            errors++; $display("FAIL zero_ready got=0 exp=1");
        end
    endtask

    task automatic test_cfg_stall;
        beat_t got [3];
        int    n;
        logic  drop, acc;
        launch(2, 2'd0, 1'b0, 5'd0);
        bus.csr_reg_set_i[0] = 32'd1;
        bus.csr_reg_set_i[1] = 32'd1;
        bus.csr_reg_set_i[2] = 32'd0;
        bus.csr_reg_set_valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (bus.csr_reg_set_ready_o !== 1'b0) begin
                errors++; $display("FAIL cfg_stall%0d got=1 exp=0", k);
            end
            @(negedge clk);
        end
        bus.acc2stream_0_ready_i = 1'b1;
        set_in(rep(16'h0010), rep(16'h0003), rep(16'h0001), 3'b111);
        n = 0; drop = 0; acc = 0;
        for (int i = 0; i < 3; i++) got[i] = '0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (drop) begin bus.csr_reg_set_valid_i = 1'b0; drop = 0; end
            if (bus.acc2stream_0_valid_o) begin
                if (n < 3) got[n] = bus.acc2stream_0_data_o;
                n++;
            end
            if (bus.csr_reg_set_valid_i && bus.csr_reg_set_ready_o) begin
                acc = 1; drop = 1;
            end
            if (n >= 3 && !bus.csr_reg_ro_set_o[0][0] && !bus.acc2stream_0_valid_o) break;
        end
        set_in('0, '0, '0, 3'b000);
        bus.csr_reg_set_valid_i = 1'b0;
        checks++;
        if (!acc || n != 3) begin
            errors++; $display("FAIL cfg_accept acc=%b beats=%0d exp=1/3", acc, n);
        end
        checks++;
        if (got[0] !== rep(16'h0014) || got[1] !== rep(16'h0014)) begin
            errors++;
            $display("FAIL cfg_run1 got=%h exp=%h", got[1], rep(16'h0014));
        end
        checks++;
        if (got[2] !== rep(16'h000C)) begin
            errors++; $display("FAIL cfg_run2 got=%h exp=%h", got[2], rep(16'h000C));
        end
    endtask

    task automatic test_reset_mid;
        int n;
        beat_t f, l;
        bus.acc2stream_0_ready_i = 1'b0;
        launch(4, 2'd0, 1'b0, 5'd0);
        set_in(rep(16'h0001), rep(16'h0001), rep(16'h0001), 3'b111);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.acc2stream_0_valid_o !== 1'b1 || bus.csr_reg_ro_set_o[0][0] !== 1'b1) begin
            errors++; $display("FAIL mid_full valid=%b busy=%b exp=1/1",
                               bus.acc2stream_0_valid_o, bus.csr_reg_ro_set_o[0][0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.acc2stream_0_valid_o !== 1'b0 || bus.acc2stream_0_data_o !== '0) begin
            errors++; $display("FAIL mid_out valid=%b data=%h exp=0/0",
                               bus.acc2stream_0_valid_o, bus.acc2stream_0_data_o);
        end
        checks++;
        if (bus.stream2acc_ready_o !== 3'b000 || bus.csr_reg_set_ready_o !== 1'b1) begin
            errors++; $display("FAIL mid_ready in=%b csr=%b exp=000/1",
                               bus.stream2acc_ready_o, bus.csr_reg_set_ready_o);
        end
        checks++;
        if (bus.csr_reg_ro_set_o[0] !== 32'd0 || bus.csr_reg_ro_set_o[1] !== 32'd0) begin
            errors++; $display("FAIL mid_ro got=%h/%h exp=0/0",
                               bus.csr_reg_ro_set_o[0], bus.csr_reg_ro_set_o[1]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_in('0, '0, '0, 3'b000);
        bus.acc2stream_0_ready_i = 1'b1;
        run(1, 2'd0, 1'b0, 5'd0, rep(16'h0004), rep(16'h0005), rep(16'h0006), n, f, l);
        checks++;
        if (n != 1 || l !== rep(16'h000F)) begin
            errors++; $display("FAIL mid_recover n=%0d got=%h exp=%h", n, l, rep(16'h000F));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_max();
        test_mul();
        test_backpressure();
        test_skew();
        test_zero();
        test_cfg_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
